// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch stage and the decode controller.
// Holds the bubble encoding, default reset PC, opcodes and the fetch buffer entry layout.
package riscv_pkg;

  localparam int          XLEN         = 32;
  localparam logic [31:0] INST_BUBBLE  = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [6:0]  OP_R   = 7'b0110011;
  localparam logic [6:0]  OP_I   = 7'b0010011;
  localparam logic [6:0]  OP_NOP = 7'b0000000;

  // One buffered fetch: request PC in the upper half, instruction word in the lower.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO; head entry is visible on rdata_o without a pop.
// Push and pop on a full FIFO in the same cycle is allowed and leaves count unchanged.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == CW'(DEPTH));
  assign count_o = r_count;
  assign rdata_o = r_mem[r_rd_ptr];

  assign w_pop  = pop_i && !empty_o && !flush_i;
  assign w_push = push_i && (!full_o || w_pop) && !flush_i;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC, credit-limited req/gnt/rvalid fetches,
// prefetch FIFO and a registered one-instruction-per-cycle output to decode.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic [31:0] pc_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int DW = 8;

  logic [31:0]   r_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_out;
  logic [DW-1:0] r_drop;
  logic [31:0]   r_inst;
  logic [31:0]   r_inst_pc;
  logic          r_valid;

  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_full;
  fetch_entry_t  w_head;
  fetch_entry_t  w_word;
  logic [CW:0]   w_inflight;
  logic          w_fire;
  logic          w_dropr;
  logic          w_take;
  logic          w_bypass;
  logic          w_pop;
  logic          w_push;
  logic [31:0]   w_flush_pc;

  // Credit covers both buffered words and in-flight fetches, so a response always has a slot.
  assign w_inflight = {1'b0, w_count} + {1'b0, r_out};
  assign imem_req_o = !rst_i && !flush_i && (w_inflight < (CW+1)'(FIFO_DEPTH));
  assign imem_addr_o = r_pc;

  assign w_fire     = imem_req_o && imem_gnt_i;
  assign w_dropr    = imem_rvalid_i && (r_drop != '0);
  assign w_take     = imem_rvalid_i && (r_drop == '0) && (r_out != '0);
  assign w_word     = '{pc: r_resp_pc, inst: imem_rdata_i};
  assign w_flush_pc = word_align(flush_pc_i);

  assign w_pop    = !flush_i && !stall_i && !w_empty;
  assign w_bypass = !flush_i && !stall_i && w_empty && w_take;
  assign w_push   = !flush_i && w_take && !w_bypass && (!w_full || w_pop);

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .wdata_i (w_word),
    .pop_i   (w_pop),
    .flush_i (flush_i),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc      <= RESET_PC;
      r_resp_pc <= RESET_PC;
      r_out     <= '0;
      r_drop    <= '0;
      r_inst    <= INST_BUBBLE;
      r_inst_pc <= RESET_PC;
      r_valid   <= 1'b0;
    end else if (flush_i) begin
      // Everything still owed by memory becomes a word to discard, minus any that lands now.
      r_pc      <= w_flush_pc;
      r_resp_pc <= w_flush_pc;
      r_out     <= '0;
      r_drop    <= r_drop - DW'(w_dropr) + DW'(r_out) - DW'(w_take) + DW'(w_fire);
      r_inst    <= INST_BUBBLE;
      r_valid   <= 1'b0;
    end else begin
      if (w_fire) r_pc      <= r_pc + 32'd4;
      if (w_take) r_resp_pc <= r_resp_pc + 32'd4;
      r_out  <= r_out + CW'(w_fire) - CW'(w_take);
      r_drop <= r_drop - DW'(w_dropr);
      if (!stall_i) begin
        if (w_pop) begin
          r_inst    <= w_head.inst;
          r_inst_pc <= w_head.pc;
          r_valid   <= 1'b1;
        end else if (w_bypass) begin
          r_inst    <= imem_rdata_i;
          r_inst_pc <= r_resp_pc;
          r_valid   <= 1'b1;
        end else begin
          r_inst    <= INST_BUBBLE;
          r_valid   <= 1'b0;
        end
      end
    end
  end

  assign inst_o       = r_inst;
  assign inst_valid_o = r_valid;
  assign pc_o         = r_inst_pc;

endmodule
